mar_seq_unit: RTL and testbench
===============================

// Module: mar_seq_unit
// PURPOSE
//  Parametrised memory address register with a built-in memory access sequencer for the CPU datapath.
//  Loads an address from the bus and drives a stable memory address.
//  Issues single read/write strobes and waits on a memory ready handshake, with a timeout.
//  Optionally post-increments the address by STRIDE for block transfers.
//  Sits between the internal bus and the RAM/MDR pair.
// PARAMETERS
//  DATA_W    32  width of bus
//  ADDR_W    9   width of the address register and q (2^ADDR_W words)
//  STRIDE    1   increment step, 1..2^ADDR_W-1
//  MAX_WAIT  15  max ACCESS cycles with mem_ready low before abort, >=1
// PORTS
//  clk        in   1       clock, all state changes on rising edge
//  clr        in   1       reset, synchronous, active-high
//  MARin      in   1       load q from bus[ADDR_W-1:0]
//  bus        in   DATA_W  internal bus contents
//  inc        in   1       IDLE alone: increment now; with rd/wr: post-increment on completion
//  rd         in   1       start read access
//  wr         in   1       start write access
//  mem_ready  in   1       memory acknowledge, sampled only in ACCESS
//  q          out  ADDR_W  current address to memory
//  mem_rd     out  1       read strobe, high throughout a read ACCESS
//  mem_wr     out  1       write strobe, high throughout a write ACCESS
//  busy       out  1       high in ACCESS and DONE
//  done       out  1       one-cycle pulse, access completed
//  timeout    out  1       sticky, last access aborted
//  wrap       out  1       one-cycle pulse, an increment carried out of ADDR_W bits
// BEHAVIOUR
//  Reset (clr=1 at edge): FSM=IDLE, q=0, wait count=0, all outputs 0.
//  - Applies from any state; an in-flight access is dropped with no done and no increment.
//  FSM: IDLE -> ACCESS -> DONE -> IDLE. All outputs are registered.
//  IDLE:
//  - Precedence: MARin > rd > wr > inc.
//  - MARin: q<=bus[ADDR_W-1:0]. Upper bus bits are ignored. rd/wr/inc in that cycle are ignored.
//  - rd=1 (rd wins if wr also 1): latch op=READ and post_inc=inc. Go to ACCESS, clear timeout and count.
//  - wr=1, rd=0: same as rd, with op=WRITE.
//  - inc only: q<=(q+STRIDE) mod 2^ADDR_W. Stay in IDLE. wrap=1 next cycle if the sum >= 2^ADDR_W.
//  ACCESS:
//  - mem_rd or mem_wr=1 per op, busy=1, q held. MARin, rd, wr and inc are ignored.
//  - mem_ready=1: go to DONE.
//  - mem_ready=0 and count<MAX_WAIT-1: count++.
//  - mem_ready=0 and count==MAX_WAIT-1: go to IDLE, timeout<=1, no done, no increment.
//  - mem_ready=1 in the abort cycle wins (completion, no timeout).
//  DONE (one cycle):
//  - done=1, busy=1, strobes 0. If post_inc: q advances by STRIDE with the wrap rule above.
//  - Go to IDLE. Requests in this cycle are ignored.
//  Latency: request sampled at edge N.
//  - Strobe high from N+1. If ready is seen at edge N+1+k, done is high after that edge.
//  - Minimum request-to-next-accept is 3 edges.
//  Strobes never assert together. A strobe never asserts outside ACCESS.
//  timeout is cleared only by clr or by acceptance of a new rd/wr.
// TESTING
//  1 Reset: clr=1 for 1 cycle mid-ACCESS, any state -> next cycle q=0, mem_rd=mem_wr=busy=done=timeout=wrap=0.
//  2 Load/read: MARin, bus=32'hFFFF_F0A5 -> q=9'h0A5.
//    - Then rd, mem_ready high 2 cycles later -> mem_rd high 3 cycles, done 1 pulse, q stays 0A5.
//  3 Block write: q=9'h1FE, STRIDE=1, wr+inc three times with immediate ready
//    -> q = 1FF, 000 (wrap pulse with that done), 001.
//  4 Timeout: MAX_WAIT=15, rd, mem_ready held 0 -> mem_rd high exactly 15 cycles, then IDLE, timeout=1, no done.
//    - Next wr -> timeout clears on accept.
//    - Ready on the 15th cycle -> done, timeout stays 0.
//  5 Conflicts: rd&wr together -> read only.
//    - MARin+rd together -> load only, stays IDLE.
//    - MARin/inc/rd during ACCESS or DONE -> q unchanged, no new access.
//  6 Standalone inc with STRIDE=4, q=9'h1FD -> q=9'h001, wrap=1 one cycle; repeat -> q=005, wrap=0.

Source files
------------

// File: rtl/mar_seq_unit.sv
// mar_seq_unit
//   Memory address register with a small access sequencer. Holds the
//   address presented to RAM, issues one read or write strobe per request,
//   waits for mem_ready (with a bounded wait), and can post-increment the
//   address by STRIDE for block transfers.
//
// Ports
//   clk        clock, rising edge
//   clr        synchronous active-high reset
//   MARin      load q from bus[ADDR_W-1:0]
//   bus        internal bus (only the low ADDR_W bits are used)
//   inc        IDLE alone: step now; with rd/wr: step after completion
//   rd, wr     start a read / write access (rd wins if both)
//   mem_ready  memory acknowledge, only looked at while accessing
//   q          address to memory
//   mem_rd     read strobe, high for the whole read access
//   mem_wr     write strobe, high for the whole write access
//   busy       high while accessing or completing
//   done       one-cycle completion pulse
//   timeout    sticky flag, last access aborted on the wait limit
//   wrap       one-cycle pulse, an address step carried out of ADDR_W bits
//
// Every output is a flop loaded from the next-state decode, so nothing
// downstream sees decode glitches. Assumes DATA_W > ADDR_W.

module mar_seq_unit #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 9,
    parameter int STRIDE   = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              MARin,
    input  logic [DATA_W-1:0] bus,
    input  logic              inc,
    input  logic              rd,
    input  logic              wr,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] q,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              wrap
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    // Counter must be able to hold MAX_WAIT-1; one spare bit keeps the
    // MAX_WAIT=1 case at a legal width.
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(MAX_WAIT - 1);
    localparam logic [ADDR_W:0]   STEP     = (ADDR_W + 1)'(STRIDE);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] q_n;
    logic              op_rd, op_rd_n;     // latched operation: 1 = read
    logic              pinc, pinc_n;       // latched post-increment request
    logic              timeout_n;
    logic              wrap_n;
    logic              mem_rd_n, mem_wr_n, busy_n, done_n;

    // Address step with carry; bit ADDR_W is the wrap indication.
    logic [ADDR_W:0]   sum;
    assign sum = {1'b0, q} + STEP;

    // Upper bus bits are intentionally ignored.
    logic unused_bus;
    assign unused_bus = ^bus[DATA_W-1:ADDR_W];

    // ------------------------------------------------------------------
    // Next-state / next-output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        q_n       = q;
        op_rd_n   = op_rd;
        pinc_n    = pinc;
        timeout_n = timeout;
        wrap_n    = 1'b0;

        unique case (state)
            S_IDLE: begin
                if (MARin) begin
                    q_n = bus[ADDR_W-1:0];
                end else if (rd || wr) begin
                    op_rd_n   = rd;
                    pinc_n    = inc;
                    cnt_n     = '0;
                    timeout_n = 1'b0;
                    state_n   = S_ACCESS;
                end else if (inc) begin
                    q_n    = sum[ADDR_W-1:0];
                    wrap_n = sum[ADDR_W];
                end
            end

            S_ACCESS: begin
                // Ready on the last allowed cycle still completes.
                if (mem_ready) begin
                    state_n = S_DONE;
                end else if (cnt == CNT_LAST) begin
                    timeout_n = 1'b1;
                    state_n   = S_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end

            S_DONE: begin
                if (pinc) begin
                    q_n    = sum[ADDR_W-1:0];
                    wrap_n = sum[ADDR_W];
                end
                state_n = S_IDLE;
            end

            default: state_n = S_IDLE;
        endcase

        mem_rd_n = (state_n == S_ACCESS) &&  op_rd_n;
        mem_wr_n = (state_n == S_ACCESS) && !op_rd_n;
        busy_n   = (state_n != S_IDLE);
        done_n   = (state_n == S_DONE);
    end

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= S_IDLE;
            cnt     <= '0;
            q       <= '0;
            op_rd   <= 1'b0;
            pinc    <= 1'b0;
            timeout <= 1'b0;
            wrap    <= 1'b0;
            mem_rd  <= 1'b0;
            mem_wr  <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            q       <= q_n;
            op_rd   <= op_rd_n;
            pinc    <= pinc_n;
            timeout <= timeout_n;
            wrap    <= wrap_n;
            mem_rd  <= mem_rd_n;
            mem_wr  <= mem_wr_n;
            busy    <= busy_n;
            done    <= done_n;
        end
    end

endmodule

// File: tb/tb_mar_seq_unit.sv
// Scoreboard bench for mar_seq_unit. Stimulus pushes the expected outcome
// of each access (done or timeout, address, op, strobe length) into a
// queue; a negedge monitor pops and compares whenever the DUT reports an
// event. Direct checks cover address/flag state between accesses. A second
// instance with STRIDE=4 covers the standalone wrap case.

module tb_mar_seq_unit;

    logic        clk = 1'b0;
    logic        clr, MARin, inc, rd, wr, mem_ready;
    logic [31:0] bus;

    logic [8:0]  q;
    logic        mem_rd, mem_wr, busy, done, timeout, wrap;
    logic [8:0]  q4;
    logic        mem_rd4, mem_wr4, busy4, done4, timeout4, wrap4;

    always #5 clk = ~clk;

    mar_seq_unit #(.DATA_W(32), .ADDR_W(9), .STRIDE(1), .MAX_WAIT(15)) u1 (
        .clk(clk), .clr(clr), .MARin(MARin), .bus(bus), .inc(inc), .rd(rd),
        .wr(wr), .mem_ready(mem_ready), .q(q), .mem_rd(mem_rd),
        .mem_wr(mem_wr), .busy(busy), .done(done), .timeout(timeout),
        .wrap(wrap)
    );

    mar_seq_unit #(.DATA_W(32), .ADDR_W(9), .STRIDE(4), .MAX_WAIT(15)) u4 (
        .clk(clk), .clr(clr), .MARin(MARin), .bus(bus), .inc(inc), .rd(rd),
        .wr(wr), .mem_ready(mem_ready), .q(q4), .mem_rd(mem_rd4),
        .mem_wr(mem_wr4), .busy(busy4), .done(done4), .timeout(timeout4),
        .wrap(wrap4)
    );

    typedef struct {
        bit       is_to;
        bit       is_rd;
        bit [8:0] q;
        int       len;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor
    // ------------------------------------------------------------------
    int run = 0, last_run = 0;
    bit run_rd = 0, last_rd = 0, prev_to = 0;

    always @(negedge clk) begin
        if (clr) begin
            run     = 0;
            prev_to = 0;
        end else begin
            if (mem_rd || mem_wr) begin
                run++;
                run_rd = mem_rd;
            end else if (run != 0) begin
                last_run = run;
                last_rd  = run_rd;
                run      = 0;
            end
            chk("strobe_excl", {mem_rd & mem_wr, (mem_rd | mem_wr) & (~busy | done)}, 0);
            if (done || (timeout && !prev_to)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_event", {done, timeout}, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("evt_kind", {done, timeout && !prev_to}, e.is_to ? 2'b01 : 2'b10);
                    chk("evt_q", q, e.q);
                    chk("evt_op_rd", last_rd, e.is_rd);
                    chk("evt_strobe_len", last_run, e.len);
                end
            end
            prev_to = timeout;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] v);
        MARin = 1'b1; bus = v;
        cyc(1);
        MARin = 1'b0;
    endtask

    // Request with {rd,wr}=req, post-inc pinc; ready held low for k cycles.
    task automatic access(input logic [1:0] req, input bit pinc, input int k,
                          input logic [8:0] q_at_done);
        exp_t e;
        e.is_to = 0; e.is_rd = req[1]; e.q = q_at_done; e.len = k + 1;
        sb.push_back(e);
        rd = req[1]; wr = req[0]; inc = pinc;
        cyc(1);
        rd = 0; wr = 0; inc = 0;
        chk("acc_busy", busy, 1);
        chk("acc_timeout_clr", timeout, 0);
        chk("acc_strobe", {mem_rd, mem_wr}, req[1] ? 2'b10 : 2'b01);
        cyc(k);
        mem_ready = 1'b1;
        cyc(1);
        mem_ready = 1'b0;
        cyc(1);
    endtask

    initial begin
        clr = 1; MARin = 0; inc = 0; rd = 0; wr = 0; mem_ready = 0; bus = '0;
        cyc(2);
        clr = 0;
        chk("reset_q", q, 0);
        chk("reset_flags", {mem_rd, mem_wr, busy, done, timeout, wrap}, 0);

        // Load and single read
        load(32'hFFFF_F0A5);
        chk("load_q", q, 9'h0A5);
        chk("load_idle", busy, 0);
        access(2'b10, 0, 2, 9'h0A5);
        chk("read_q_held", q, 9'h0A5);

        // Block write with post-increment through the wrap
        load(32'h0000_01FE);
        access(2'b01, 1, 0, 9'h1FE);
        chk("blk1_q", q, 9'h1FF); chk("blk1_wrap", wrap, 0);
        access(2'b01, 1, 0, 9'h1FF);
        chk("blk2_q", q, 9'h000); chk("blk2_wrap", wrap, 1);
        access(2'b01, 1, 0, 9'h000);
        chk("blk3_q", q, 9'h001); chk("blk3_wrap", wrap, 0);

        // Timeout: 15 strobe cycles, no done
        begin
            exp_t e;
            e.is_to = 1; e.is_rd = 1; e.q = 9'h001; e.len = 15;
            sb.push_back(e);
        end
        rd = 1;
        cyc(1);
        rd = 0;
        cyc(15);
        chk("to_flag", timeout, 1);
        chk("to_idle", busy, 0);
        cyc(1);
        chk("to_sticky", timeout, 1);
        chk("to_q", q, 9'h001);
        // Next access clears timeout on accept; ready on the last cycle wins
        access(2'b01, 0, 14, 9'h001);
        chk("late_ready_no_to", timeout, 0);

        // rd and wr together -> read
        access(2'b11, 0, 1, 9'h001);

        // MARin with rd -> load only
        MARin = 1; rd = 1; bus = 32'h0000_0123;
        cyc(1);
        MARin = 0; rd = 0;
        chk("marin_rd_q", q, 9'h123);
        chk("marin_rd_idle", busy, 0);
        cyc(1);
        chk("marin_rd_noacc", {busy, mem_rd, mem_wr}, 0);

        // Requests during ACCESS and DONE are ignored
        begin
            exp_t e;
            e.is_to = 0; e.is_rd = 1; e.q = 9'h123; e.len = 3;
            sb.push_back(e);
        end
        rd = 1;
        cyc(1);
        MARin = 1; inc = 1; rd = 1; bus = 32'h0000_0055;
        cyc(2);
        chk("ign_acc_q", q, 9'h123);
        mem_ready = 1;
        cyc(1);
        mem_ready = 0;
        chk("ign_done_q", q, 9'h123);
        cyc(1);
        MARin = 0; inc = 0; rd = 0;
        chk("ign_after_q", q, 9'h123);
        cyc(1);
        chk("ign_no_new", {busy, q}, {1'b0, 9'h123});

        // Standalone increment, STRIDE=4
        load(32'h0000_01FD);
        chk("s4_load", q4, 9'h1FD);
        inc = 1;
        cyc(1);
        inc = 0;
        chk("s4_inc1_q", q4, 9'h001); chk("s4_inc1_wrap", wrap4, 1);
        cyc(1);
        chk("s4_wrap_pulse", wrap4, 0);
        inc = 1;
        cyc(1);
        inc = 0;
        chk("s4_inc2_q", q4, 9'h005); chk("s4_inc2_wrap", wrap4, 0);

        // Reset mid-ACCESS drops the access
        load(32'h0000_0077);
        rd = 1; inc = 1;
        cyc(1);
        rd = 0; inc = 0;
        cyc(2);
        chk("pre_clr_strobe", mem_rd, 1);
        clr = 1;
        cyc(1);
        clr = 0;
        chk("clr_q", q, 0);
        chk("clr_flags", {mem_rd, mem_wr, busy, done, timeout, wrap}, 0);
        cyc(3);
        chk("clr_stays_idle", {busy, done, q}, 0);

        chk("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
